// File: rtl/motor_pkg.sv
// Shared direction encoding, sequencer state type and ramp helper
// for the motor speed sequencer.
package motor_pkg;

    localparam logic [2:0] DIR_STOP  = 3'b000;
    localparam logic [2:0] DIR_FWD   = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_BWD   = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b100;

    localparam int MAX_LEVEL_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DEAD,
        ESTOP
    } seq_state_t;

    function automatic logic [2:0] step_toward(
        input logic [2:0] cur,
        input logic [2:0] tgt
    );
        logic [2:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 3'd1;
        end else if (cur > tgt) begin
            nxt = cur - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running counter/comparator PWM; only instantiated when
// MOTOR_SEQ_PWM_EN is defined.
module motor_pwm_gen #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] duty_i,
    output logic         pwm_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt_d = cnt_q + W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // duty == 0 never satisfies the compare, so the output stays low
    assign pwm_o = (cnt_q < duty_i);

endmodule

// File: rtl/motor_speed_sequencer.sv
// Ramps motor speed level by level, drains and dead-times direction changes,
// handles e-stop. Define MOTOR_SEQ_PWM_EN to generate pwm_out internally.
module motor_speed_sequencer
    import motor_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int DEADTIME  = 25,
    parameter int DUTY_STEP = 32,
    parameter int MAX_LEVEL = MAX_LEVEL_DEF,
    parameter int DUTY_W    = 8
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic [2:0]        dir_cmd,
    input  logic [2:0]        target_speed,
    input  logic              estop,
    output logic [2:0]        motor_dir,
    output logic [DUTY_W-1:0] duty,
    output logic [2:0]        cur_speed,
    output logic              at_speed,
    output logic              busy,
    output logic              pwm_out
);

    localparam int CW       = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int DW       = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
    localparam int DUTY_MAX = (1 << DUTY_W) - 1;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [2:0]    spd_q, spd_d;
    logic [2:0]    dir_q, dir_d;
    logic          tick;
    logic [2:0]    tgt_clamp;
    logic [2:0]    eff_tgt;
    logic [DUTY_W-1:0] duty_sat;
    int            prod;

    assign tick   = (tick_q == CW'(TICK_DIV - 1));
    assign tick_d = tick ? '0 : tick_q + CW'(1);

    assign tgt_clamp = (int'(target_speed) > MAX_LEVEL) ?
                       3'(MAX_LEVEL) : target_speed;
    assign eff_tgt   = (dir_cmd == DIR_STOP || state_q == DRAIN) ?
                       3'd0 : tgt_clamp;

    always_comb begin
        state_d = state_q;
        spd_d   = spd_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        if (estop) begin
            state_d = ESTOP;
            spd_d   = '0;
            dir_d   = DIR_STOP;
            dead_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    spd_d = '0;
                    if (dir_cmd != DIR_STOP) begin
                        dir_d   = dir_cmd;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // a direction change outranks any pending retarget
                    if (dir_cmd != dir_q) begin
                        state_d = DRAIN;
                        if (tick && spd_q != 3'd0) begin
                            spd_d = spd_q - 3'd1;
                        end
                    end else if (tick) begin
                        spd_d = step_toward(spd_q, eff_tgt);
                    end
                end
                DRAIN: begin
                    if (spd_q == 3'd0) begin
                        dead_d  = DW'(DEADTIME);
                        state_d = DEAD;
                    end else if (dir_cmd == dir_q) begin
                        state_d = RUN;
                    end else if (tick) begin
                        spd_d = spd_q - 3'd1;
                    end
                end
                DEAD: begin
                    spd_d = '0;
                    if (tick) begin
                        if (dead_q <= DW'(1)) begin
                            dead_d = '0;
                            dir_d  = dir_cmd;
                            state_d = (dir_cmd == DIR_STOP) ? IDLE : RUN;
                        end else begin
                            dead_d = dead_q - DW'(1);
                        end
                    end
                end
                ESTOP: begin
                    spd_d = '0;
                    dir_d = DIR_STOP;
                    if (dir_cmd == DIR_STOP) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            dead_q  <= '0;
            spd_q   <= '0;
            dir_q   <= DIR_STOP;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dead_q  <= dead_d;
            spd_q   <= spd_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        prod     = int'(spd_q) * DUTY_STEP;
        duty_sat = (prod > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : DUTY_W'(prod);
    end

    // estop kills drive in the same cycle, ahead of the registered path
    assign duty      = estop ? '0 : duty_sat;
    assign motor_dir = dir_q;
    assign cur_speed = spd_q;
    assign at_speed  = (state_q == RUN) && (spd_q == eff_tgt);
    assign busy      = ((state_q == RUN) && (spd_q != eff_tgt)) ||
                       (state_q == DRAIN) || (state_q == DEAD) ||
                       (state_q == ESTOP);

`ifdef MOTOR_SEQ_PWM_EN
    motor_pwm_gen #(
        .W(DUTY_W)
    ) u_pwm (
        .clk_i (CLOCK_50),
        .rst_ni(rst_n),
        .duty_i(duty),
        .pwm_o (pwm_out)
    );
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_motor_speed_sequencer.sv
// Scoreboard bench: expected speed/direction steps are queued by the
// stimulus and consumed by a monitor whenever the DUT output steps.
module tb_motor_speed_sequencer;
    import motor_pkg::*;

    typedef struct packed {
        logic [2:0] dir;
        logic [2:0] spd;
        logic [7:0] duty;
        logic       at;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dir_cmd = DIR_STOP;
    logic [2:0] target_speed = 3'd0;
    logic       estop = 1'b0;
    logic [2:0] motor_dir;
    logic [7:0] duty;
    logic [2:0] cur_speed;
    logic       at_speed;
    logic       busy;
    logic       pwm_out;

    exp_t exp_q[$];
    int   stamps[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    motor_speed_sequencer #(
        .TICK_DIV (4),
        .DEADTIME (2),
        .DUTY_STEP(32),
        .MAX_LEVEL(6),
        .DUTY_W   (8)
    ) dut (
        .CLOCK_50    (clk),
        .rst_n       (rst_n),
        .dir_cmd     (dir_cmd),
        .target_speed(target_speed),
        .estop       (estop),
        .motor_dir   (motor_dir),
        .duty        (duty),
        .cur_speed   (cur_speed),
        .at_speed    (at_speed),
        .busy        (busy),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [2:0] d, input logic [2:0] s,
                        input logic [7:0] du, input logic a, input logic b);
        exp_t e;
        e.dir = d; e.spd = s; e.duty = du; e.at = a; e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses outstanding, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_motor_dir"}, int'(motor_dir), int'(DIR_STOP));
        chk({tag, "_cur_speed"}, int'(cur_speed), 0);
        chk({tag, "_duty"}, int'(duty), 0);
        chk({tag, "_at_speed"}, int'(at_speed), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pwm_out"}, int'(pwm_out), 0);
    endtask

    // Monitor: an output step is any change of {motor_dir, cur_speed}
    initial begin
        logic [5:0] prev;
        exp_t e;
        exp_t act;
        wait (mon_en);
        prev = {motor_dir, cur_speed};
        forever begin
            @(negedge clk);
            if ({motor_dir, cur_speed} != prev) begin
                prev = {motor_dir, cur_speed};
                act.dir = motor_dir; act.spd = cur_speed; act.duty = duty;
                act.at = at_speed; act.busy = busy;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step: got dir=%0d spd=%0d duty=%0d, expected no change",
                             act.dir, act.spd, act.duty);
                end else begin
                    e = exp_q.pop_front();
                    stamps.push_back(cyc);
                    if (act != e) begin
                        errors++;
                        $display("FAIL scoreboard: got dir=%0d spd=%0d duty=%0d at=%0d busy=%0d, expected dir=%0d spd=%0d duty=%0d at=%0d busy=%0d",
                                 act.dir, act.spd, act.duty, act.at, act.busy,
                                 e.dir, e.spd, e.duty, e.at, e.busy);
                    end
                end
            end
        end
    end

    initial begin
        int i0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_release_busy", int'(busy), 0);
        mon_en = 1'b1;

        // ramp up forward to level 3
        push(DIR_FWD, 3'd0, 8'd0, 1'b0, 1'b1);
        push(DIR_FWD, 3'd1, 8'd32, 1'b0, 1'b1);
        push(DIR_FWD, 3'd2, 8'd64, 1'b0, 1'b1);
        push(DIR_FWD, 3'd3, 8'd96, 1'b1, 1'b0);
        dir_cmd = DIR_FWD;
        target_speed = 3'd3;
        wait_drain("s1_ramp_up");

        // reverse briefly, return before zero: no dead-time
        i0 = stamps.size();
        push(DIR_FWD, 3'd2, 8'd64, 1'b0, 1'b1);
        dir_cmd = DIR_BWD;
        wait_drain("s3_drain_step");
        push(DIR_FWD, 3'd3, 8'd96, 1'b1, 1'b0);
        dir_cmd = DIR_FWD;
        wait_drain("s3_reclimb");
        chk("s3_reclimb_cycles",
            (stamps.size() > i0 + 1) ? stamps[i0+1] - stamps[i0] : -1, 4);

        // full reversal: drain, 2 ticks dead-time, ramp backward
        i0 = stamps.size();
        push(DIR_FWD, 3'd2, 8'd64, 1'b0, 1'b1);
        push(DIR_FWD, 3'd1, 8'd32, 1'b0, 1'b1);
        push(DIR_FWD, 3'd0, 8'd0, 1'b0, 1'b1);
        push(DIR_BWD, 3'd0, 8'd0, 1'b0, 1'b1);
        push(DIR_BWD, 3'd1, 8'd32, 1'b0, 1'b1);
        push(DIR_BWD, 3'd2, 8'd64, 1'b0, 1'b1);
        push(DIR_BWD, 3'd3, 8'd96, 1'b1, 1'b0);
        dir_cmd = DIR_BWD;
        wait_drain("s2_reverse");
        chk("s2_deadtime_cycles",
            (stamps.size() > i0 + 3) ? stamps[i0+3] - stamps[i0+2] : -1, 8);

        // target above MAX_LEVEL clamps to 6
        push(DIR_BWD, 3'd4, 8'd128, 1'b0, 1'b1);
        push(DIR_BWD, 3'd5, 8'd160, 1'b0, 1'b1);
        push(DIR_BWD, 3'd6, 8'd192, 1'b1, 1'b0);
        target_speed = 3'd7;
        wait_drain("s4_clamp");
        repeat (8) @(posedge clk);
        #1;
        chk("s4_hold_speed", int'(cur_speed), 6);
        chk("s4_duty", int'(duty), 192);
`ifdef MOTOR_SEQ_PWM_EN
        begin : pwm_blk
            int hi;
            hi = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                if (pwm_out) hi++;
            end
            chk("s4_pwm_high_count", hi, 192);
        end
        @(posedge clk);
        #1;
`endif

        // ramp down to 4, then emergency stop
        push(DIR_BWD, 3'd5, 8'd160, 1'b0, 1'b1);
        push(DIR_BWD, 3'd4, 8'd128, 1'b1, 1'b0);
        target_speed = 3'd4;
        wait_drain("s5_down_to_4");
        push(DIR_STOP, 3'd0, 8'd0, 1'b0, 1'b1);
        estop = 1'b1;
        #1;
        chk("s5_estop_duty_same_cycle", int'(duty), 0);
        chk("s5_estop_pwm_same_cycle", int'(pwm_out), 0);
        chk("s5_estop_dir_before_edge", int'(motor_dir), int'(DIR_BWD));
        chk("s5_estop_speed_before_edge", int'(cur_speed), 4);
        wait_drain("s5_estop");
        estop = 1'b0;
        dir_cmd = DIR_FWD;
        repeat (12) @(posedge clk);
        #1;
        chk("s5_held_dir", int'(motor_dir), int'(DIR_STOP));
        chk("s5_held_busy", int'(busy), 1);
        chk("s5_held_duty", int'(duty), 0);
        dir_cmd = DIR_STOP;
        repeat (3) @(posedge clk);
        #1;
        chk("s5_rearm_busy", int'(busy), 0);
        push(DIR_FWD, 3'd0, 8'd0, 1'b0, 1'b1);
        push(DIR_FWD, 3'd1, 8'd32, 1'b0, 1'b1);
        push(DIR_FWD, 3'd2, 8'd64, 1'b1, 1'b0);
        dir_cmd = DIR_FWD;
        target_speed = 3'd2;
        wait_drain("s5_restart");

        // stop command: drain, dead-time, back to idle
        push(DIR_FWD, 3'd1, 8'd32, 1'b0, 1'b1);
        push(DIR_FWD, 3'd0, 8'd0, 1'b0, 1'b1);
        push(DIR_STOP, 3'd0, 8'd0, 1'b0, 1'b0);
        dir_cmd = DIR_STOP;
        wait_drain("stop_to_idle");

        // asynchronous reset in the middle of a ramp
        push(DIR_FWD, 3'd0, 8'd0, 1'b0, 1'b1);
        push(DIR_FWD, 3'd1, 8'd32, 1'b0, 1'b1);
        push(DIR_FWD, 3'd2, 8'd64, 1'b0, 1'b1);
        push(DIR_FWD, 3'd3, 8'd96, 1'b0, 1'b1);
        dir_cmd = DIR_FWD;
        target_speed = 3'd6;
        wait_drain("s6_ramp");
        push(DIR_STOP, 3'd0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("s6_async");
        dir_cmd = DIR_STOP;
        wait_drain("s6_reset_step");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("s6_after_release_dir", int'(motor_dir), int'(DIR_STOP));
        chk("s6_after_release_busy", int'(busy), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
